// File: rtl/frame_buffer.sv
// frame_buffer: 8-bit pixel store with a valid/ready write FIFO and a registered display read port.
// Define FB_CLEAR_EN to build in the whole-buffer fill sequencer (busy/clear_req/clear_value).
module frame_buffer #(
    parameter int NUM_PIXELS = 65536,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clear_req,
    input  logic [7:0]  clear_value,
    output logic        busy,
    input  logic [15:0] readAddress,
    output logic [7:0]  pixeles
);
    localparam int          AW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam logic [16:0] NP    = 17'(NUM_PIXELS);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);

    logic [15:0]   fa_q [FIFO_DEPTH];
    logic [7:0]    fd_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          push, pop, empty, in_rng;

    logic [7:0]    mem_q [NUM_PIXELS];
    logic [7:0]    pixeles_q;
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    assign empty    = (cnt_q == '0);
    assign push     = wr_valid && ready_q;
    assign wr_ready = ready_q;
    assign in_rng   = ({1'b0, fa_q[rptr_q]} < NP);

    // Full flag is registered from the post-update count, so a pop never frees a slot in its own cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
        ready_d = (cnt_d != DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fa_q[wptr_q] <= wr_addr;
            fd_q[wptr_q] <= wr_data;
        end
    end

`ifdef FB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [AW-1:0] LAST = AW'(NUM_PIXELS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cptr_q, cptr_d;
    logic [7:0]    cval_q, cval_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cptr_q  <= '0;
            cval_q  <= '0;
        end else begin
            state_q <= state_d;
            cptr_q  <= cptr_d;
            cval_q  <= cval_d;
        end
    end

    // A clear request beats a pending FIFO entry; queued writes land after the fill.
    always_comb begin
        state_d = state_q;
        cptr_d  = cptr_q;
        cval_d  = cval_q;
        pop     = 1'b0;
        we      = 1'b0;
        waddr   = fa_q[rptr_q][AW-1:0];
        wdata   = fd_q[rptr_q];
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cptr_d  = '0;
                    cval_d  = clear_value;
                end else if (!empty) begin
                    pop = 1'b1;
                    we  = in_rng;
                end
            end
            CLEAR: begin
                we     = 1'b1;
                waddr  = cptr_q;
                wdata  = cval_q;
                cptr_d = cptr_q + 1'b1;
                if (cptr_q == LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CLEAR);
`else
    logic unused_clear;
    assign unused_clear = ^{clear_req, clear_value};

    always_comb begin
        pop   = !empty;
        we    = !empty && in_rng;
        waddr = fa_q[rptr_q][AW-1:0];
        wdata = fd_q[rptr_q];
    end

    assign busy = 1'b0;
`endif

    // Writes are suppressed on a reset edge so an aborted clear stops exactly where it was.
    always_ff @(posedge clk) begin
        if (we && !rst) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)                              pixeles_q <= '0;
        else if ({1'b0, readAddress} < NP)    pixeles_q <= mem_q[readAddress[AW-1:0]];
        else                                  pixeles_q <= '0;
    end

    assign pixeles = pixeles_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer (NUM_PIXELS=16, FIFO_DEPTH=4): queue/memory reference
// model checked every cycle, plus directed literal expectations. Clear scenarios need FB_CLEAR_EN.
module tb_frame_buffer;
    localparam int NP    = 16;
    localparam int DEPTH = 4;
`ifdef FB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_valid = 1'b0, clear_req = 1'b0;
    logic [15:0] wr_addr = '0, readAddress = '0;
    logic [7:0]  wr_data = '0, clear_value = '0;
    logic        wr_ready, busy;
    logic [7:0]  pixeles;

    always #5 clk = ~clk;

    frame_buffer #(.NUM_PIXELS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_value(clear_value), .busy(busy),
        .readAddress(readAddress), .pixeles(pixeles)
    );

    int n_chk = 0, n_fail = 0, busy_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, pending-write queue and remaining-fill count.
    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t        q[$];
    logic [7:0] m_mem [NP];
    bit         m_known [NP];
    int         clr_left = 0;
    logic [7:0] clr_val = '0;
    logic [7:0] e_pix = '0;
    bit         e_pix_known = 1'b0, e_ready = 1'b0, e_busy = 1'b0, started = 1'b0;

    always @(posedge clk) begin
        bit  acc;
        wr_t e;
        if (rst) begin
            q.delete();
            clr_left    = 0;
            e_pix       = '0;
            e_pix_known = 1'b1;
            e_ready     = 1'b0;
            e_busy      = 1'b0;
        end else begin
            if (readAddress >= NP) begin
                e_pix = '0; e_pix_known = 1'b1;
            end else begin
                e_pix = m_mem[readAddress]; e_pix_known = m_known[readAddress];
            end
            acc = wr_valid && e_ready;
            if (clr_left > 0) begin
                m_mem[NP-clr_left] = clr_val; m_known[NP-clr_left] = 1'b1;
                clr_left--;
            end else if (CLR_EN && clear_req) begin
                clr_left = NP; clr_val = clear_value;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (e.a < NP) begin m_mem[e.a] = e.d; m_known[e.a] = 1'b1; end
            end
            if (acc) begin e.a = wr_addr; e.d = wr_data; q.push_back(e); end
            e_ready = (q.size() < DEPTH);
            e_busy  = (clr_left > 0);
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, e_busy);
            chk("wr_ready", wr_ready, e_ready);
            if (e_pix_known) chk("pixeles", pixeles, e_pix);
            if (busy) busy_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves wr_valid high so back-to-back calls stream; caller drops it afterwards.
    task automatic push(input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        while (!wr_ready && n < 200) begin tick(); n++; end
        if (!wr_ready) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout: addr %0d never accepted", a);
        end
        tick();
    endtask

    task automatic readall();
        for (int i = 0; i < NP; i++) begin readAddress = 16'(i); tick(); end
    endtask

    task automatic rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
        readAddress = a; tick(); chk(nm, pixeles, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk("rst_ready0", wr_ready, 0); chk("rst_busy0", busy, 0); chk("rst_pix0", pixeles, 0);
        tick();
        chk("rst_ready1", wr_ready, 0); chk("rst_busy1", busy, 0); chk("rst_pix1", pixeles, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", wr_ready, 1); chk("busy_after_rst", busy, 0);

        // Known image: addr i = 0x80+i
        for (int i = 0; i < NP; i++) push(16'(i), 8'(8'h80 + i));
        wr_valid = 1'b0;
        repeat (4) tick();
        readall();

        // Write visibility / read-during-write
        readAddress = 16'd5;
        push(16'd5, 8'hA7);
        wr_valid = 1'b0;
        tick(); chk("rdw_old", pixeles, 8'h85);
        tick(); chk("rdw_new", pixeles, 8'hA7);

        // Out of range
        push(16'd20, 8'hFF);
        wr_valid = 1'b0;
        repeat (3) tick();
        readall();
        rd("oor_read16", 16'd16, 8'h00);
        rd("oor_readFFFF", 16'hFFFF, 8'h00);
        rd("oor_alias4", 16'd4, 8'h84);

`ifdef FB_CLEAR_EN
        // Clear with backpressure and an ignored second request
        busy_cyc = 0;
        clear_req = 1'b1; clear_value = 8'h3C;
        tick();
        clear_req = 1'b0; clear_value = 8'h00;
        chk("clr_busy_start", busy, 1);
        tick(); tick();
        clear_req = 1'b1; clear_value = 8'h55;
        tick();
        clear_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) push(16'(i), 8'(8'h10 + i));
        chk("bp_ready_low", wr_ready, 0);
        push(16'd4, 8'h14);
        wr_valid = 1'b0;
        repeat (8) tick();
        chk("busy_cycles", busy_cyc, 16);
        readall();
        rd("bp_addr0", 16'd0, 8'h10);
        rd("bp_addr4", 16'd4, 8'h14);
        rd("clr_addr9", 16'd9, 8'h3C);

        // Reset in the middle of a clear drops the fill and the queued writes
        clear_req = 1'b1; clear_value = 8'hC3;
        tick();
        clear_req = 1'b0;
        push(16'd10, 8'h77);
        push(16'd11, 8'h78);
        wr_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", busy, 0); chk("midrst_ready", wr_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_ready_after", wr_ready, 1); chk("midrst_busy_after", busy, 0);
        repeat (4) tick();
        readall();
        rd("midrst_addr0", 16'd0, 8'hC3);
        rd("midrst_addr7", 16'd7, 8'hC3);
        rd("midrst_addr8", 16'd8, 8'h3C);
        rd("midrst_addr10", 16'd10, 8'h3C);
`else
        // Without the fill sequencer, clear_req is inert and the FIFO streams through
        clear_req = 1'b1; clear_value = 8'h3C;
        for (int i = 0; i < 5; i++) push(16'(i), 8'(8'h10 + i));
        wr_valid = 1'b0;
        chk("noclr_busy", busy, 0);
        clear_req = 1'b0;
        repeat (4) tick();
        readall();
        rd("stream_addr0", 16'd0, 8'h10);
        rd("stream_addr4", 16'd4, 8'h14);
        rd("noclr_addr9", 16'd9, 8'h89);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
